axis_frame_guard: RTL
=====================

// Module: axis_frame_guard
// PURPOSE
//  Frame-length guard placed directly upstream of axis_fifo_adapter_wrapper (FRAME_FIFO/DROP_BAD_FRAME use).
//  Counts beats per frame and truncates any frame longer than cfg_max_beats.
//  A truncated frame gets a forced tlast and its tuser bad-frame bit set, so the downstream FIFO drops or flags it.
//  The remaining input beats of that frame are discarded. One-stage skid-buffered output, full throughput.
// PARAMETERS
//  LEN_WIDTH             16    width of cfg_max_beats and the internal beat counter
//  USER_BAD_FRAME_VALUE  1'b1  value written to out tuser[0] on a truncated last beat
//  STAT_WIDTH            32    width of the statistics counters
// PORTS
//  clk                  in   1          clock
//  reset                in   1          synchronous, active-high reset
//  in_axis_if           -    AXIS_IF.Slave   input stream; TUSER_WIDTH >= 1 (asserted)
//  out_axis_if          -    AXIS_IF.Master  output stream; widths equal to in_axis_if (asserted)
//  cfg_max_beats        in   LEN_WIDTH  max beats per frame; 0 = limit disabled
//  status_good_frame    out  1          1-cycle pulse: untruncated tlast beat written to the skid stage
//  status_truncated     out  1          1-cycle pulse: forced-tlast beat written to the skid stage
//  stat_frames          out  STAT_WIDTH frames emitted, including truncated ones
//  stat_truncated       out  STAT_WIDTH frames truncated
// BEHAVIOUR
//  Interface: one clock (clk), synchronous active-high reset (reset).
//  Reset values: out tvalid=0, in tready=0 during reset, skid empty, state=PASS, beat_cnt=0, limit=0,
//   status pulses=0, stat counters=0.
//  Reset mid-frame: the partial frame already emitted is not terminated. The downstream FIFO owns recovery.
//  Reset mid-frame, input side: the next input beat starts a new frame.
//  FSM states: PASS, DROP.
//  PASS, limit sampling: on the first beat of a frame (beat_cnt==0) latch limit=cfg_max_beats.
//   Mid-frame changes of cfg_max_beats have no effect.
//  PASS, accepted beat: a beat is accepted when in tvalid && in tready. beat_cnt++.
//   tlast=1  -> beat forwarded unchanged; beat_cnt:=0; status_good_frame pulses.
//   tlast=0, limit!=0, beat_cnt+1==limit -> forward with tlast forced 1 and tuser[0]=USER_BAD_FRAME_VALUE.
//    Other tuser bits pass through. status_truncated pulses; go to DROP.
//   A frame that ends exactly at limit (tlast on beat==limit) is good, not truncated.
//  DROP: in tready=1 unconditionally; beats are discarded and not forwarded.
//   DROP exits on an accepted beat with tlast: go to PASS, beat_cnt:=0.
//  Handshake: in tready = skid not full (PASS) | 1 (DROP).
//   out tvalid is never deasserted without an out tready.
//   tdata, tkeep, tstrb, tid, tdest and tuser stay stable while stalled.
//  Latency: 1 cycle input->output. Sustains 1 beat/cycle with out tready held high.
//  Skid: main register plus skid register.
//   Skid register fills only when out tready drops while a beat is being accepted.
//   in tready is registered, i.e. it depends only on skid occupancy.
//  Counters: beat_cnt saturates at 2^LEN_WIDTH-1 when limit=0.
//   stat_* counters wrap modulo 2^STAT_WIDTH.
//  Simultaneous events: skid drains and accepts in the same cycle -> no bubble.
//   DROP tlast and the next frame's first beat arrive on consecutive cycles -> no gap.
// CONFIGURATION
//  AXIS_FRAME_GUARD_STATS_EN defined:
//   stat_frames increments on every emitted tlast beat; stat_truncated increments on each truncation.
//  AXIS_FRAME_GUARD_STATS_EN undefined: the counters are not built; stat_frames and stat_truncated tied to '0.
//  The status_* pulses are present in both builds.
// STRUCTURE
//  axis_frame_guard_pkg: typedef enum logic {PASS, DROP} guard_state_t; TUSER bad-bit index constant (0).
//  Sub-module axis_frame_guard_skid: generic 2-entry register slice carrying {tdata, tkeep, tstrb,
//   tlast, tid, tdest, tuser} as a flat vector. Top holds FSM, counters, tlast/tuser override.
// TESTING
//  1. limit=4; frame of 3 beats (tlast on 3) -> 3 out beats, tuser[0]=0, one status_good_frame, stat_frames=1.
//  2. limit=4; frame of 4 beats -> 4 out beats, last has tlast=1, tuser[0]=0, no status_truncated.
//  3. limit=4; frame of 10 beats, then 2-beat frame ->
//     out 4 beats, 4th tlast=1/tuser[0]=1; beats 5-10 dropped; next frame intact;
//     stat_truncated=1, stat_frames=2.
//  4. limit=0; 5000-beat frame -> all beats forwarded unchanged, no truncation.
//  5. Random out tready (50%), 1000 frames of random length 1-20, limit=8 ->
//     no lost/duplicated beats vs model; out payload stable under stall; throughput 1/cycle when tready=1.
//  6. reset asserted during beat 6 of a truncated frame in DROP ->
//     out tvalid=0 next cycle; next frame of 2 beats passes untruncated.

Source files
------------

// File: rtl/axis_frame_guard_pkg.sv
// Shared types and constants for the AXI-Stream frame-length guard.
package axis_frame_guard_pkg;

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } guard_state_t;

    // tuser bit that carries the bad-frame flag to the downstream frame FIFO
    localparam int USER_BAD_BIT = 0;

endpackage

// File: rtl/axis_frame_guard_if.sv
// AXI-Stream bus bundle used on both sides of the frame guard.
interface AXIS_IF #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [KEEP_WIDTH-1:0] tstrb;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tvalid;
    logic                  tready;

    modport Master (
        output tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
        input  tready
    );

    modport Slave (
        input  tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
        output tready
    );
endinterface

// File: rtl/axis_frame_guard_skid.sv
// Two-entry register slice (main + skid) with a registered upstream ready.
module axis_frame_guard_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);
    // p0 is the output (main) register, p1 the skid register
    logic             r_vld_p0;
    logic             r_vld_p1;
    logic [WIDTH-1:0] r_data_p0;
    logic [WIDTH-1:0] r_data_p1;
    logic             w_accept;
    logic             w_main_load;

    assign o_ready     = ~r_vld_p1;
    assign w_accept    = i_valid & ~r_vld_p1;
    assign w_main_load = i_ready | ~r_vld_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else if (w_main_load) begin
            r_vld_p0 <= r_vld_p1 | w_accept;
            r_vld_p1 <= 1'b0;
        end else if (w_accept) begin
            r_vld_p1 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_main_load && r_vld_p1) begin
            r_data_p0 <= r_data_p1;
        end else if (w_main_load && w_accept) begin
            r_data_p0 <= i_data;
        end
        if (!w_main_load && w_accept) begin
            r_data_p1 <= i_data;
        end
    end

    assign o_valid = r_vld_p0;
    assign o_data  = r_data_p0;

endmodule

// File: rtl/axis_frame_guard.sv
// AXI-Stream frame-length guard: truncates frames longer than cfg_max_beats and flags them bad in tuser.
// Frame/truncation statistics counters are built only when AXIS_FRAME_GUARD_STATS_EN is defined.
module axis_frame_guard
    import axis_frame_guard_pkg::*;
#(
    parameter int   DATA_WIDTH           = 32,
    parameter int   KEEP_WIDTH           = (DATA_WIDTH + 7) / 8,
    parameter int   ID_WIDTH             = 8,
    parameter int   DEST_WIDTH           = 8,
    parameter int   USER_WIDTH           = 1,
    parameter int   LEN_WIDTH            = 16,
    parameter logic USER_BAD_FRAME_VALUE = 1'b1,
    parameter int   STAT_WIDTH           = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    AXIS_IF.Slave                 in_axis_if,
    AXIS_IF.Master                out_axis_if,
    input  logic [LEN_WIDTH-1:0]  cfg_max_beats,
    output logic                  status_good_frame,
    output logic                  status_truncated,
    output logic [STAT_WIDTH-1:0] stat_frames,
    output logic [STAT_WIDTH-1:0] stat_truncated
);
    localparam int PW = DATA_WIDTH + 2 * KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
    localparam logic [0:0] ST_PASS = PASS;
    localparam logic [0:0] ST_DROP = DROP;

    if (USER_WIDTH < 1) begin : g_bad_user_width
        $error("axis_frame_guard: TUSER width must be at least 1");
    end

    logic [0:0]            r_state;
    logic [LEN_WIDTH-1:0]  r_beat_cnt;
    logic [LEN_WIDTH-1:0]  r_limit;
    logic                  r_status_good;
    logic                  r_status_trunc;

    logic                  w_pass;
    logic                  w_skid_ready;
    logic                  w_accept;
    logic [LEN_WIDTH-1:0]  w_limit;
    logic                  w_at_limit;
    logic                  w_force_last;
    logic                  w_good;
    logic                  w_trunc;
    logic [USER_WIDTH-1:0] w_user;
    logic [PW-1:0]         w_in_data;
    logic [PW-1:0]         w_out_data;

    assign w_pass               = (r_state == ST_PASS);
    assign in_axis_if.tready    = ~reset & (~w_pass | w_skid_ready);
    assign w_accept             = in_axis_if.tvalid & in_axis_if.tready;

    // The limit is taken live from cfg on a frame's first beat, from the latch afterwards
    assign w_limit      = (r_beat_cnt == '0) ? cfg_max_beats : r_limit;
    assign w_at_limit   = (w_limit != '0) &&
                          (({1'b0, r_beat_cnt} + (LEN_WIDTH + 1)'(1)) == {1'b0, w_limit});
    assign w_force_last = w_at_limit & ~in_axis_if.tlast;
    assign w_good       = w_accept & w_pass & in_axis_if.tlast;
    assign w_trunc      = w_accept & w_pass & w_force_last;

    always_comb begin
        w_user = in_axis_if.tuser;
        if (w_force_last) begin
            w_user[USER_BAD_BIT] = USER_BAD_FRAME_VALUE;
        end
    end

    assign w_in_data = {in_axis_if.tdata, in_axis_if.tkeep, in_axis_if.tstrb,
                        in_axis_if.tlast | w_force_last,
                        in_axis_if.tid, in_axis_if.tdest, w_user};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_PASS;
            r_beat_cnt     <= '0;
            r_limit        <= '0;
            r_status_good  <= 1'b0;
            r_status_trunc <= 1'b0;
        end else begin
            r_status_good  <= w_good;
            r_status_trunc <= w_trunc;
            if (w_accept) begin
                if (w_pass) begin
                    if (r_beat_cnt == '0) begin
                        r_limit <= cfg_max_beats;
                    end
                    if (in_axis_if.tlast) begin
                        r_beat_cnt <= '0;
                    end else if (w_at_limit) begin
                        r_beat_cnt <= '0;
                        r_state    <= ST_DROP;
                    end else if (r_beat_cnt != '1) begin
                        r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
                    end
                end else if (in_axis_if.tlast) begin
                    r_beat_cnt <= '0;
                    r_state    <= ST_PASS;
                end
            end
        end
    end

    axis_frame_guard_skid #(
        .WIDTH (PW)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_valid (in_axis_if.tvalid & w_pass),
        .i_data  (w_in_data),
        .o_ready (w_skid_ready),
        .o_valid (out_axis_if.tvalid),
        .o_data  (w_out_data),
        .i_ready (out_axis_if.tready)
    );

    assign {out_axis_if.tdata, out_axis_if.tkeep, out_axis_if.tstrb, out_axis_if.tlast,
            out_axis_if.tid, out_axis_if.tdest, out_axis_if.tuser} = w_out_data;

    assign status_good_frame = r_status_good;
    assign status_truncated  = r_status_trunc;

`ifdef AXIS_FRAME_GUARD_STATS_EN
    logic [STAT_WIDTH-1:0] r_stat_frames;
    logic [STAT_WIDTH-1:0] r_stat_trunc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_frames <= '0;
            r_stat_trunc  <= '0;
        end else begin
            if (w_good || w_trunc) begin
                r_stat_frames <= r_stat_frames + STAT_WIDTH'(1);
            end
            if (w_trunc) begin
                r_stat_trunc <= r_stat_trunc + STAT_WIDTH'(1);
            end
        end
    end

    assign stat_frames    = r_stat_frames;
    assign stat_truncated = r_stat_trunc;
`else
    assign stat_frames    = '0;
    assign stat_truncated = '0;
`endif

endmodule
